// File: rtl/io_command_sequencer.sv
// io_command_sequencer
// Initiator side of the IO execution unit's instruction interface. Takes one
// command at a time from the control core and issues it to the IO unit as a
// single-cycle strobe. The operands stay on the IO unit's inputs until the
// next command is accepted. A start timeout and a per-command watchdog
// supervise the command, and the result comes back on a valid/ready
// response channel.
module io_command_sequencer #(
  parameter int          INSTRUCTION_SIZE = 3,
  parameter int          SIZE_WORD        = 5,
  parameter int          AUXILIAR_SIZE    = 44,
  parameter int          IO_OUTPUT_SIZE   = 8,
  parameter logic [43:0] ONE_SECOND_CLOCK = 44'h00007735940,
  parameter int          START_TIMEOUT    = 4,
  parameter int          WD_MARGIN        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  // command channel from the control core
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [INSTRUCTION_SIZE-1:0] cmd_op,
  input  logic [SIZE_WORD-1:0]        cmd_reg,
  input  logic [AUXILIAR_SIZE-1:0]    cmd_aux,
  // instruction interface to the IO unit
  output logic [INSTRUCTION_SIZE-1:0] instrucction,
  output logic [SIZE_WORD-1:0]        register,
  output logic [AUXILIAR_SIZE-1:0]    auxiliar_register,
  output logic                        valid_instrucction,
  input  logic                        busy,
  input  logic                        valid_io,
  input  logic [IO_OUTPUT_SIZE-1:0]   result_input_io,
  // response channel to the control core
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [INSTRUCTION_SIZE-1:0] rsp_op,
  output logic [IO_OUTPUT_SIZE-1:0]   rsp_data,
  output logic [1:0]                  rsp_status,
  output logic [15:0]                 cmd_count
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ISSUE      = 3'd1;
  localparam logic [2:0] WAIT_START = 3'd2;
  localparam logic [2:0] WAIT_DONE  = 3'd3;
  localparam logic [2:0] DRAIN      = 3'd4;
  localparam logic [2:0] RESP       = 3'd5;

  localparam logic [1:0] STATUS_OK       = 2'b00;
  localparam logic [1:0] STATUS_START_TO = 2'b01;
  localparam logic [1:0] STATUS_WD_TO    = 2'b10;

  // Read opcodes: two single-pin reads and one parallel read.
  localparam logic [INSTRUCTION_SIZE-1:0] OP_READ_BIT_A = INSTRUCTION_SIZE'(4);
  localparam logic [INSTRUCTION_SIZE-1:0] OP_READ_BIT_B = INSTRUCTION_SIZE'(5);
  localparam logic [INSTRUCTION_SIZE-1:0] OP_READ_PAR   = INSTRUCTION_SIZE'(6);

  // The watchdog allows for the longest delay the aux operand can request,
  // plus two seconds of IO unit overhead and a small margin.
  localparam int          WD_W    = 48;
  localparam logic [47:0] WD_BASE = ({4'b0, ONE_SECOND_CLOCK} << 1) + WD_W'(WD_MARGIN);

  localparam int             ST_W    = $clog2(START_TIMEOUT + 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(START_TIMEOUT - 1);

  logic [2:0]                  state_q, state_d;
  logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
  logic [SIZE_WORD-1:0]        reg_q, reg_d;
  logic [AUXILIAR_SIZE-1:0]    aux_q, aux_d;
  logic [WD_W-1:0]             wd_cnt_q, wd_cnt_d;
  logic [ST_W-1:0]             st_cnt_q, st_cnt_d;
  logic [ST_W-1:0]             st_inc;
  logic [IO_OUTPUT_SIZE-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]                  rsp_status_q, rsp_status_d;
  logic [15:0]                 cmd_count_q, cmd_count_d;
  logic [IO_OUTPUT_SIZE-1:0]   read_data;

  // Handshake and strobe outputs are decoded directly from the state.
  assign cmd_ready          = (state_q == IDLE);
  assign valid_instrucction = (state_q == ISSUE);
  assign rsp_valid          = (state_q == RESP);

  assign instrucction      = instr_q;
  assign register          = reg_q;
  assign auxiliar_register = aux_q;
  assign rsp_op            = instr_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_status        = rsp_status_q;
  assign cmd_count         = cmd_count_q;

  assign st_inc = st_cnt_q + ST_W'(1);

  // Select the part of the IO unit result that the current opcode returns.
  // valid_io is deliberately not used: a read of 0 and a read of 1 look the
  // same on that line, so it cannot qualify the capture.
  always_comb begin
    read_data = '0;
    if (instr_q == OP_READ_PAR) begin
      read_data = result_input_io;
    end else if (instr_q == OP_READ_BIT_A || instr_q == OP_READ_BIT_B) begin
      read_data = IO_OUTPUT_SIZE'(result_input_io[0]);
    end
  end

  // Sequencer FSM: next-state and next-value logic for every register.
  // NOTE: every signal gets a default at the top so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    reg_d        = reg_q;
    aux_d        = aux_q;
    wd_cnt_d     = wd_cnt_q;
    st_cnt_d     = st_cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    cmd_count_d  = cmd_count_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          instr_d = cmd_op;
          reg_d   = cmd_reg;
          aux_d   = cmd_aux;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        wd_cnt_d = WD_W'(aux_q) + WD_BASE;
        st_cnt_d = '0;
        state_d  = WAIT_START;
      end

      WAIT_START: begin
        // Only busy counts as a start, even if valid_io pulses first.
        if (busy) begin
          state_d = WAIT_DONE;
        end else begin
          st_cnt_d = st_inc;
          if (st_inc == ST_LAST) begin
            rsp_status_d = STATUS_START_TO;
            state_d      = RESP;
          end
        end
      end

      WAIT_DONE: begin
        if (busy) begin
          if (wd_cnt_q == '0) begin
            rsp_status_d = STATUS_WD_TO;
            state_d      = DRAIN;
          end else begin
            wd_cnt_d = wd_cnt_q - WD_W'(1);
          end
        end else begin
          rsp_status_d = STATUS_OK;
          rsp_data_d   = read_data;
          state_d      = RESP;
        end
      end

      // The IO unit cannot be aborted. Wait for it to go idle so that the
      // next command does not overlap the timed-out one.
      DRAIN: begin
        if (!busy) begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (rsp_status_q == STATUS_OK) begin
            cmd_count_d = cmd_count_q + 16'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      reg_q        <= '0;
      aux_q        <= '0;
      wd_cnt_q     <= '0;
      st_cnt_q     <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= STATUS_OK;
      cmd_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      reg_q        <= reg_d;
      aux_q        <= aux_d;
      wd_cnt_q     <= wd_cnt_d;
      st_cnt_q     <= st_cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      cmd_count_q  <= cmd_count_d;
    end
  end

endmodule

// File: tb/tb_io_command_sequencer.sv
// Testbench for io_command_sequencer. Directed steps in one initial block.
// The bench plays both the control core and a simple IO unit. Expected
// responses go into a scoreboard queue when each command is offered, and
// they are popped and compared when the response channel presents them.
module tb_io_command_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_reg;
  logic [43:0] cmd_aux;
  logic [2:0]  instrucction;
  logic [4:0]  register;
  logic [43:0] auxiliar_register;
  logic        valid_instrucction;
  logic        busy;
  logic        valid_io;
  logic [7:0]  result_input_io;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_op;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_status;
  logic [15:0] cmd_count;

  io_command_sequencer #(
    .ONE_SECOND_CLOCK (44'd10)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_op             (cmd_op),
    .cmd_reg            (cmd_reg),
    .cmd_aux            (cmd_aux),
    .instrucction       (instrucction),
    .register           (register),
    .auxiliar_register  (auxiliar_register),
    .valid_instrucction (valid_instrucction),
    .busy               (busy),
    .valid_io           (valid_io),
    .result_input_io    (result_input_io),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_op             (rsp_op),
    .rsp_data           (rsp_data),
    .rsp_status         (rsp_status),
    .cmd_count          (cmd_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
    logic [1:0] status;
    logic       chk_data;
  } rsp_t;

  rsp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = '0;
  logic [2:0]  cur_op;
  logic [4:0]  cur_reg;
  logic [43:0] cur_aux;
  logic [43:0] par_aux;
  int          n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_data(input logic [2:0] op, input logic [7:0] res);
    if (op == 3'b110) return res;
    if (op == 3'b100 || op == 3'b101) return {7'b0, res[0]};
    return 8'h00;
  endfunction

  // Called on the falling edge of the cycle that should be ISSUE.
  task automatic check_issue();
    check("issue_strobe", valid_instrucction, 1'b1);
    check("issue_cmd_ready", cmd_ready, 1'b0);
    check("issue_op", instrucction, cur_op);
    check("issue_reg", register, cur_reg);
    check("issue_aux", auxiliar_register, cur_aux);
  endtask

  task automatic accept(input logic [2:0] op, input logic [4:0] rg, input logic [43:0] aux,
                        input logic [7:0] res, input logic [1:0] st, input logic chk);
    int w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    check("accept_ready", cmd_ready, 1'b1);
    cur_op = op; cur_reg = rg; cur_aux = aux;
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = rg; cmd_aux = aux;
    sb_q.push_back('{op, exp_data(op, res), st, chk});
    tick();
    cmd_valid = 1'b0;
    check_issue();
  endtask

  // IO unit model: busy is high for busy_cycles starting the cycle after
  // the strobe, and the result is presented as busy drops.
  task automatic serve(input int busy_cycles, input logic [7:0] res);
    tick();
    for (int i = 0; i < busy_cycles; i++) begin
      busy = 1'b1;
      result_input_io = ~res;
      tick();
      check("busy_no_strobe", valid_instrucction, 1'b0);
      check("busy_reg_hold", register, cur_reg);
      check("busy_aux_hold", auxiliar_register, cur_aux);
    end
    busy = 1'b0;
    result_input_io = res;
    valid_io = 1'b1;
    tick();
    valid_io = 1'b0;
  endtask

  task automatic get_resp(input int ready_delay, input bit present_next);
    int   w = 0;
    rsp_t e;
    while (!rsp_valid && w < 100) begin tick(); w++; end
    check("rsp_valid_wait", rsp_valid, 1'b1);
    e = sb_q.pop_front();
    for (int d = 0; d < ready_delay; d++) begin
      check("bp_cmd_ready", cmd_ready, 1'b0);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_op", rsp_op, e.op);
      check("bp_rsp_status", rsp_status, e.status);
      if (e.chk_data) check("bp_rsp_data", rsp_data, e.data);
      tick();
    end
    check("rsp_op", rsp_op, e.op);
    check("rsp_status", rsp_status, e.status);
    if (e.chk_data) check("rsp_data", rsp_data, e.data);
    rsp_ready = 1'b1;
    if (present_next) begin
      cmd_valid = 1'b1; cmd_op = 3'b111; cmd_reg = 5'd31; cmd_aux = 44'hABC;
    end
    if (e.status == 2'b00) exp_count++;
    tick();
    rsp_ready = 1'b0;
    check("idle_cmd_ready", cmd_ready, 1'b1);
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("idle_no_strobe", valid_instrucction, 1'b0);
    check("cmd_count", cmd_count, exp_count);
  endtask

  initial begin
    par_aux = {5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 9'd0};
    rst = 1'b1; busy = 1'b0; valid_io = 1'b0; result_input_io = '0; rsp_ready = 1'b0;
    // A command is already offered while reset is held.
    cmd_valid = 1'b1; cmd_op = 3'b110; cmd_reg = 5'd3; cmd_aux = par_aux;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_strobe", valid_instrucction, 1'b0);
    check("rst_instr", instrucction, 3'd0);
    check("rst_reg", register, 5'd0);
    check("rst_aux", auxiliar_register, 44'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_op", rsp_op, 3'd0);
    check("rst_rsp_data", rsp_data, 8'd0);
    check("rst_rsp_status", rsp_status, 2'd0);
    check("rst_cmd_count", cmd_count, 16'd0);

    // Parallel read, accepted on the first cycle out of reset.
    cur_op = 3'b110; cur_reg = 5'd3; cur_aux = par_aux;
    sb_q.push_back('{3'b110, exp_data(3'b110, 8'hA5), 2'b00, 1'b1});
    rst = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check_issue();
    serve(1, 8'hA5);
    check("min_latency_rsp_valid", rsp_valid, 1'b1);
    get_resp(0, 1'b0);

    // Single-pin read with a long busy period: only bit 0 is returned.
    accept(3'b100, 5'd9, 44'd10, 8'hFF, 2'b00, 1'b1);
    serve(11, 8'hFF);
    get_resp(0, 1'b0);

    // Start timeout: busy never rises, and a lone valid_io must not count.
    accept(3'b001, 5'd7, 44'd5, 8'h00, 2'b01, 1'b0);
    n = 0;
    valid_io = 1'b1;
    while (!rsp_valid && n < 20) begin tick(); n++; valid_io = 1'b0; end
    check("start_to_latency", n, 4);
    get_resp(0, 1'b0);

    // Watchdog: busy held far past the 36-cycle budget while another command
    // is offered. The response appears only once busy is released.
    accept(3'b000, 5'd1, 44'd0, 8'h33, 2'b10, 1'b0);
    tick();
    busy = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'b110; cmd_reg = 5'd20; cmd_aux = 44'h123;
    for (int i = 0; i < 60; i++) begin
      tick();
      check("wd_no_rsp", rsp_valid, 1'b0);
      check("wd_cmd_ready", cmd_ready, 1'b0);
      check("wd_no_strobe", valid_instrucction, 1'b0);
      check("wd_op_hold", instrucction, 3'b000);
    end
    busy = 1'b0;
    cmd_valid = 1'b0;
    tick();
    check("drain_rsp_valid", rsp_valid, 1'b1);
    get_resp(0, 1'b0);

    // Backpressure on the response; the next command is offered during the
    // handshake and must wait one idle cycle.
    accept(3'b101, 5'd2, 44'd3, 8'hFE, 2'b00, 1'b1);
    serve(3, 8'hFE);
    get_resp(5, 1'b1);
    cur_op = 3'b111; cur_reg = 5'd31; cur_aux = 44'hABC;
    sb_q.push_back('{3'b111, exp_data(3'b111, 8'h77), 2'b00, 1'b1});
    tick();
    cmd_valid = 1'b0;
    check_issue();
    serve(2, 8'h77);
    get_resp(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
